// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter that shares one SRAM-like memory port between the
// instruction-fetch side and the data side, with one transaction outstanding at a time.
module cpu_mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        grant_reg, grant_next;
  logic        last_reg, last_next;
  logic        wr_reg, wr_next;
  logic [1:0]  size_reg, size_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;

  logic        pick_data;
  logic        addr_hit;
  logic        data_hit;
  logic [1:0]  addr_ok_vec;
  logic [1:0]  data_ok_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= 1'b0;
      last_reg  <= !DATA_FIRST;
      wr_reg    <= 1'b0;
      size_reg  <= 2'd0;
      wstrb_reg <= 4'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      wr_reg    <= wr_next;
      size_reg  <= size_next;
      wstrb_reg <= wstrb_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    wr_next    = wr_reg;
    size_next  = size_reg;
    wstrb_next = wstrb_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    mem_req    = 1'b0;
    addr_hit   = 1'b0;
    data_hit   = 1'b0;
    // On a tie the side that did not win last time goes first.
    pick_data  = data_req && (!inst_req || !last_reg);
    case (state_reg)
      IDLE: begin
        if (inst_req || data_req) begin
          state_next = REQ;
          grant_next = pick_data;
          if (pick_data) begin
            wr_next    = data_wr;
            size_next  = data_size;
            wstrb_next = data_wstrb;
            addr_next  = data_addr;
            wdata_next = data_wdata;
          end else begin
            wr_next    = 1'b0;
            size_next  = inst_size;
            wstrb_next = 4'd0;
            addr_next  = inst_addr;
            wdata_next = 32'd0;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          addr_hit   = 1'b1;
          last_next  = grant_reg;
          state_next = RESP;
        end
      end
      RESP: begin
        if (mem_data_ok) begin
          data_hit   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Index 0 is the inst side, index 1 the data side, matching the grant encoding.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_route
      assign addr_ok_vec[gi] = addr_hit && (grant_reg == 1'(gi));
      assign data_ok_vec[gi] = data_hit && (grant_reg == 1'(gi));
    end
  endgenerate

  assign inst_addr_ok = addr_ok_vec[0];
  assign data_addr_ok = addr_ok_vec[1];
  assign inst_data_ok = data_ok_vec[0];
  assign data_data_ok = data_ok_vec[1];
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign mem_wr    = wr_reg;
  assign mem_size  = size_reg;
  assign mem_wstrb = wstrb_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: arbitration table, directed multi-cycle corner
// cases, then randomized traffic against a transaction-level reference model.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [1:0]  inst_size = 2'd2;
  logic [31:0] inst_addr = 32'hBFC00000;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = 2'd2;
  logic [3:0]  data_wstrb = 4'd0;
  logic [31:0] data_addr = 32'h80000000;
  logic [31:0] data_wdata = 32'd0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  cpu_mem_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic [5:0]  exp_flags;   // {mem_req, busy, inst_aok, inst_dok, data_aok, data_dok}
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [5:0] flags();
    return {mem_req, busy, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Reference model state for randomized traffic
  logic        pend_i, pend_d;
  logic [1:0]  ri_size;
  logic [31:0] ri_addr;
  logic        rd_wr;
  logic [1:0]  rd_size;
  logic [3:0]  rd_wstrb;
  logic [31:0] rd_addr, rd_wdata;
  int          phase;       // 0 free, 1 waiting for accept, 2 waiting for response
  logic        win, last_side;
  logic [6:0]  exp_ctl;
  logic [63:0] exp_aw;
  logic [5:0]  ef;
  int          ndok;
  int          txns;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  6'b000000, 32'h00000000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  6'b110010, 32'h80000000};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hA1, 6'b010001, 32'h80000000};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  6'b000000, 32'h80000000};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  6'b111000, 32'hBFC00000};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hB2, 6'b010100, 32'hBFC00000};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  6'b000000, 32'hBFC00000};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  6'b110010, 32'h80000000};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hC3, 6'b010001, 32'h80000000};

    // Reset state
    next();
    settle();
    check("reset_flags", flags(), 6'b0);
    check("reset_fields", {mem_wr, mem_size, mem_wstrb}, 7'd0);
    check("reset_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
    next();
    reset = 1'b0;

    // Round-robin tie sequence after reset: data, inst, data
    for (int i = 0; i < 9; i++) begin
      inst_req = tbl[i].ireq; data_req = tbl[i].dreq;
      mem_addr_ok = tbl[i].aok; mem_data_ok = tbl[i].dok; mem_rdata = tbl[i].rdata;
      settle();
      check($sformatf("tbl%0d_flags", i), flags(), tbl[i].exp_flags);
      check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
      check($sformatf("tbl%0d_rdata", i), {inst_rdata, data_rdata}, {tbl[i].rdata, tbl[i].rdata});
      $display("tbl row %0d: flags=%b addr=%h", i, flags(), mem_addr);
      next();
    end

    // Single inst fetch with immediate handshakes
    inst_req = 1'b1; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    settle();
    check("fetch_c0", flags(), 6'b000000);
    next();
    mem_addr_ok = 1'b1;
    settle();
    check("fetch_c1", flags(), 6'b111000);
    check("fetch_addr", mem_addr, 32'hBFC00000);
    next();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
    settle();
    check("fetch_c2", flags(), 6'b010100);
    check("fetch_rdata", inst_rdata, 32'h12345678);
    $display("fetch: rdata=%h", inst_rdata);
    next();

    // Store with a stalled accept and a stalled response
    mem_data_ok = 1'b0; ndok = 0;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'b0011;
    data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
    settle();
    ndok += int'(data_data_ok);
    next();
    for (int k = 0; k < 3; k++) begin
      mem_addr_ok = (k == 2);
      settle();
      check("store_ctl", {mem_wr, mem_size, mem_wstrb}, {1'b1, 2'd1, 4'b0011});
      check("store_aw", {mem_addr, mem_wdata}, {32'h80000010, 32'hDEADBEEF});
      ndok += int'(data_data_ok);
      if (k == 2) check("store_accept", flags(), 6'b110010);
      next();
    end
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0; mem_addr_ok = 1'b0;
    settle(); ndok += int'(data_data_ok); next();
    mem_data_ok = 1'b1;
    settle();
    check("store_done", flags(), 6'b010001);
    ndok += int'(data_data_ok);
    next();
    mem_data_ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle(); ndok += int'(data_data_ok); next();
    end
    check("store_dok_count", ndok, 1);
    $display("store: data_data_ok pulses=%0d", ndok);

    // Accept stalled 5 cycles; a new inst request must wait
    data_req = 1'b1; data_size = 2'd2; data_addr = 32'h80000020;
    settle(); next();
    for (int k = 0; k < 5; k++) begin
      inst_req = (k >= 1);
      settle();
      check("stall_addr", mem_addr, 32'h80000020);
      check("stall_flags", flags(), 6'b110000);
      next();
    end
    mem_addr_ok = 1'b1;
    settle(); check("stall_accept", flags(), 6'b110010); next();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle(); check("stall_resp", flags(), 6'b010001); next();
    mem_data_ok = 1'b0;
    settle(); check("stall_idle", flags(), 6'b000000); next();
    mem_addr_ok = 1'b1;
    settle(); check("pending_inst_accept", flags(), 6'b111000); next();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle(); check("pending_inst_resp", flags(), 6'b010100); next();
    $display("stall: pending inst served after data");

    // Stray data_ok in IDLE and REQ; simultaneous handshakes in REQ
    mem_data_ok = 1'b1;
    settle(); check("stray_idle", flags(), 6'b000000); next();
    mem_data_ok = 1'b0;
    settle(); check("stray_idle_after", flags(), 6'b000000);
    data_req = 1'b1; data_addr = 32'h80000030;
    next();
    mem_data_ok = 1'b1;
    settle(); check("stray_req", flags(), 6'b110000); next();
    mem_addr_ok = 1'b1;
    settle(); check("both_ok_req", flags(), 6'b110010); next();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    settle(); check("both_ok_resp_wait", flags(), 6'b010000); next();
    mem_data_ok = 1'b1;
    settle(); check("both_ok_resp", flags(), 6'b010001); next();
    mem_data_ok = 1'b0;
    $display("stray: handshakes outside their state ignored");

    // Reset while in RESP
    inst_req = 1'b1;
    settle(); next();
    mem_addr_ok = 1'b1;
    settle(); check("rst_accept", flags(), 6'b111000); next();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    settle(); check("rst_in_resp", flags(), 6'b010000);
    reset = 1'b1;
    next();
    reset = 1'b0; mem_rdata = 32'd0;
    settle();
    check("rst_flags", flags(), 6'b0);
    check("rst_fields", {mem_wr, mem_size, mem_wstrb}, 7'd0);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
    next();
    mem_data_ok = 1'b1;
    settle(); check("rst_late_dok", flags(), 6'b0); next();
    mem_data_ok = 1'b0;
    $display("reset in RESP: transaction abandoned");

    // Randomized traffic against the transaction-level model
    reset = 1'b1; next(); next(); reset = 1'b0;
    pend_i = 1'b0; pend_d = 1'b0; phase = 0; last_side = 1'b0; win = 1'b0;
    exp_ctl = '0; exp_aw = '0; txns = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend_i && $urandom_range(0, 3) == 0) begin
        pend_i = 1'b1; ri_size = 2'($urandom_range(0, 2)); ri_addr = $urandom;
      end
      if (!pend_d && $urandom_range(0, 3) == 0) begin
        pend_d = 1'b1; rd_wr = 1'($urandom); rd_size = 2'($urandom_range(0, 2));
        rd_wstrb = 4'($urandom); rd_addr = $urandom; rd_wdata = $urandom;
      end
      inst_req = pend_i; inst_size = ri_size; inst_addr = ri_addr;
      data_req = pend_d; data_wr = rd_wr; data_size = rd_size;
      data_wstrb = rd_wstrb; data_addr = rd_addr; data_wdata = rd_wdata;
      mem_addr_ok = ($urandom_range(0, 2) == 0);
      mem_data_ok = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      settle();
      case (phase)
        1: ef = {2'b11, !win && mem_addr_ok, 1'b0, win && mem_addr_ok, 1'b0};
        2: ef = {2'b01, 1'b0, !win && mem_data_ok, 1'b0, win && mem_data_ok};
        default: ef = 6'b000000;
      endcase
      check("rand_flags", flags(), ef);
      check("rand_rdata", {inst_rdata, data_rdata}, {mem_rdata, mem_rdata});
      if (phase == 1) begin
        check("rand_ctl", {mem_wr, mem_size, mem_wstrb}, exp_ctl);
        check("rand_aw", {mem_addr, mem_wdata}, exp_aw);
      end
      case (phase)
        0: if (pend_i || pend_d) begin
          win = (pend_i && pend_d) ? !last_side : pend_d;
          if (win) begin
            exp_ctl = {rd_wr, rd_size, rd_wstrb}; exp_aw = {rd_addr, rd_wdata};
          end else begin
            exp_ctl = {1'b0, ri_size, 4'd0}; exp_aw = {ri_addr, 32'd0};
          end
          phase = 1;
        end
        1: if (mem_addr_ok) begin
          last_side = win;
          if (win) pend_d = 1'b0; else pend_i = 1'b0;
          phase = 2;
        end
        2: if (mem_data_ok) begin
          phase = 0;
          txns++;
        end
        default: phase = 0;
      endcase
      next();
    end
    $display("random: %0d transactions completed", txns);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
